// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

   typedef enum logic [2:0] {LEN0, LEN1, DATA, DONE, ERR} state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Collects instruction bytes LSB-first; word_out is the complete word in the
// cycle the final byte is presented.
module byte_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        shift,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic [1:0]  idx,
   output logic        word_complete
);

   logic [23:0] shreg;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg <= '0;
         idx   <= '0;
      end else if (clear) begin
         shreg <= '0;
         idx   <= '0;
      end else if (shift) begin
         shreg <= {byte_in, shreg[23:8]};
         idx   <= idx + 2'd1;
      end
   end

   assign word_complete = shift && (idx == 2'(BYTES_PER_WORD - 1));
   assign word_out      = {byte_in, shreg};

endmodule

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader that fills instruction memory and holds
// the processor in reset until the whole image has been written.
module prog_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reload,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam logic [16:0] CAPACITY = 17'(1 << ADDR_WIDTH);

   state_t              state;
   logic [7:0]          len_lo;
   logic [ADDR_WIDTH:0] n_words;
   logic [15:0]         hdr_n;
   logic                accept;
   logic                shift;
   logic                word_complete;
   logic [31:0]         word;
   logic [1:0]          byte_idx;

   assign accept = in_valid & in_ready;
   assign hdr_n  = {in_data, len_lo};
   // A byte arriving together with reload is dropped, so it never reaches the assembler.
   assign shift  = accept & (state == DATA) & ~reload;

   byte_assembler u_asm (
      .clk           (clk),
      .rst           (rst),
      .clear         (reload),
      .shift         (shift),
      .byte_in       (in_data),
      .word_out      (word),
      .idx           (byte_idx),
      .word_complete (word_complete)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= LEN0;
         len_lo       <= '0;
         n_words      <= '0;
         in_ready     <= 1'b1;
         cpu_hold     <= 1'b1;
         load_error   <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         words_loaded <= '0;
      end else begin
         // NOTE: default-low strobe each cycle gives exactly one write pulse per assembled word.
         imem_we <= 1'b0;
         if (reload) begin
            state        <= LEN0;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            load_error   <= 1'b0;
            words_loaded <= '0;
         end else begin
            case (state)
               LEN0: if (accept) begin
                  len_lo <= in_data;
                  state  <= LEN1;
               end
               LEN1: if (accept) begin
                  n_words <= (ADDR_WIDTH + 1)'(hdr_n);
                  if (hdr_n == 16'd0) begin
                     state    <= DONE;
                     in_ready <= 1'b0;
                  end else if ({1'b0, hdr_n} > CAPACITY) begin
                     state      <= ERR;
                     in_ready   <= 1'b0;
                     load_error <= 1'b1;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: if (word_complete) begin
                  imem_we      <= 1'b1;
                  imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                  imem_wdata   <= word;
                  words_loaded <= words_loaded + 1'b1;
                  if (words_loaded + 1'b1 == n_words) begin
                     state    <= DONE;
                     in_ready <= 1'b0;
                  end
               end
               // Hold drops one edge after entering DONE, so the last write has committed.
               DONE: cpu_hold <= 1'b0;
               ERR:  cpu_hold <= 1'b1;
               default: state <= LEN0;
            endcase
         end
      end
   end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of `SingleCycleProcessor`. It receives a length-prefixed byte stream over a valid/ready interface, assembles little-endian 32-bit instructions, and writes them word-by-word into instruction memory. It holds the processor in reset until the whole image is written, so the core's first fetch sees a complete program.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: instruction-memory word-address width; capacity 2^ADDR_WIDTH words.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `reload`  input  1  synchronous restart pulse; valid in any state.
- `in_valid`  input  1  byte-stream valid.
- `in_data`  input  8  byte-stream data.
- `in_ready`  output  1  loader accepts a byte; handshake is `in_valid & in_ready` at a rising edge.
- `imem_we`  output  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  output  ADDR_WIDTH  word address of the write.
- `imem_wdata`  output  32  instruction word.
- `cpu_hold`  output  1  1 holds the processor in reset. Connected to the core's reset through the top-level polarity adapter.
- `load_error`  output  1  frame length exceeds capacity.
- `words_loaded`  output  ADDR_WIDTH+1  count of words written in the current load.

## Operation
- Frame format: 2-byte word count N, little-endian, followed by 4·N instruction bytes. Each instruction is sent least-significant byte first.
- States:
  - LEN0: capture N[7:0]. Next state is LEN1.
  - LEN1: capture N[15:8]. Next state:
    - N==0 → DONE.
    - N>2^ADDR_WIDTH → ERR.
    - Otherwise → DATA.
  - DATA: byte index 0..3 goes into a shift assembler.
    - On the 4th byte, the word is registered for write.
    - The word index increments.
    - After word N−1, next state is DONE.
  - DONE: `cpu_hold`=0 and `in_ready`=0. Further input is not accepted.
  - ERR: `load_error`=1, `cpu_hold`=1, `in_ready`=0.
- `in_ready`=1 in LEN0, LEN1 and DATA. It is never deasserted mid-frame, because each write completes in one cycle.
- `reload` in any state:
  - Next state is LEN0.
  - Byte index, word index, `words_loaded` and `load_error` are cleared.
  - `cpu_hold` becomes 1.
  - A partial word is discarded and not written.
  - A byte handshaking in the same cycle as `reload` is dropped.
- Words are written at consecutive addresses starting at 0. `imem_addr` equals the word index at assembly time.
- `words_loaded` increments in the same cycle `imem_we` is high.
- Width rules:
  - N is 16-bit, compared zero-extended against 2^ADDR_WIDTH.
  - N = 2^ADDR_WIDTH is legal and fills memory exactly.
  - The word index never wraps.

## Timing
- Reset values (asynchronous, `rst`=0):
  - State = LEN0.
  - `cpu_hold`=1, `in_ready`=1.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `load_error`=0, `words_loaded`=0.
- Reset asserted mid-load aborts immediately; no write strobe is issued afterwards.
- Write latency: when the 4th byte handshakes at edge k, `imem_we`/`imem_addr`/`imem_wdata` are high/valid for exactly the cycle between edges k and k+1.
- Back-to-back words:
  - One byte per cycle gives one write every 4 cycles.
  - Stalls on `in_valid` only delay the write; they never split or duplicate it.
- Completion: if the last word's 4th byte handshakes at edge k, then `cpu_hold` falls at edge k+1. The processor leaves reset only after the final write has committed.
- The N==0 frame goes LEN1 → DONE. `cpu_hold` falls the edge after N[15:8] is accepted.
- ERR: `load_error` rises at the edge that accepts N[15:8].

## Structure
- `loader_pkg`:
  - state enum {LEN0, LEN1, DATA, DONE, ERR}.
  - `HDR_BYTES`=2.
  - `BYTES_PER_WORD`=4.
- One sub-module, `byte_assembler`:
  - Takes byte in, shift enable and clear.
  - Produces a 32-bit word out and a 2-bit index.
  - Flags `word_complete` on the 4th byte.
- `prog_loader` holds the FSM, the counters and the output registers.

## Test plan
- Reset with `rst`=0, then release. Expect `cpu_hold`=1, `in_ready`=1, `imem_we`=0, `words_loaded`=0.
- Stream 02 00, 93 02 50 00, 13 03 A0 00 with no gaps. Expect:
  - Write 0x00500293 at address 0, then 0x00A00313 at address 1, 4 cycles apart.
  - `cpu_hold` falls one cycle after the second write.
  - `words_loaded`=2.
- Same frame with `in_valid` toggled randomly. Expect identical writes with no duplicates.
- `imem_we` is high for exactly one cycle per word.
- Header N=0x0101 with ADDR_WIDTH=8. Expect `load_error`=1, `in_ready`=0, `cpu_hold` stays 1.
- Header N=0x0100. Expect 256 writes, addresses 0..255, then DONE.
- Cases for `reload` and reset:
  - After 2 bytes of a word, pulse `reload`. Expect no write, state LEN0, `words_loaded`=0, `cpu_hold`=1.
  - A fresh 1-word frame then writes at address 0.
  - Asserting `rst` mid-frame forces all reset values immediately.
